// File: rtl/tsf_event_scheduler.sv
// tsf_event_scheduler: four-slot TSF compare/alarm scheduler with a round-robin valid/ready event port.
// Defining TSF_EVENT_MISS_CNT_EN adds miss_cnt, per-slot 8-bit saturating overrun counters.
module tsf_event_scheduler #(
    parameter int TIMER_WIDTH  = 64,
    parameter int PERIOD_WIDTH = 32,
    parameter int NUM_SLOT     = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [TIMER_WIDTH-1:0]  tsf_runtime_val,
    input  logic                    cfg_wr,
    input  logic [1:0]              cfg_slot,
    input  logic                    cfg_enable,
    input  logic [TIMER_WIDTH-1:0]  cfg_target,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    output logic                    event_valid,
    input  logic                    event_ready,
    output logic [1:0]              event_id,
    output logic [TIMER_WIDTH-1:0]  event_target,
`ifdef TSF_EVENT_MISS_CNT_EN
    output logic [31:0]             miss_cnt,
`endif
    output logic [NUM_SLOT-1:0]     slot_enable,
    output logic [NUM_SLOT-1:0]     slot_pending
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state, next_state;
    logic [TIMER_WIDTH-1:0]  target   [NUM_SLOT];
    logic [TIMER_WIDTH-1:0]  fire_val [NUM_SLOT];
    logic [PERIOD_WIDTH-1:0] period   [NUM_SLOT];
    logic [NUM_SLOT-1:0]     due, wr_hit, accept_hit;
    logic [1:0]              rr, pick;
    logic                    load_evt, accept;
    // A config write to a slot overrides its due update in the same cycle
    always_comb begin
        for (int i = 0; i < NUM_SLOT; i++) begin
            wr_hit[i]     = cfg_wr && (cfg_slot == 2'(i));
            due[i]        = slot_enable[i] && (tsf_runtime_val >= target[i]) && !wr_hit[i];
            accept_hit[i] = accept && (event_id == 2'(i));
        end
    end
    // Highest k is overwritten by lower ones, so the nearest pending at/after rr wins
    always_comb begin
        pick = rr;
        for (int k = NUM_SLOT - 1; k >= 0; k--)
            if (slot_pending[rr + 2'(k)]) pick = rr + 2'(k);
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end
    always_comb begin
        next_state = state;
        if (state == IDLE) next_state = |slot_pending ? PRESENT : IDLE;
        else               next_state = event_ready ? IDLE : PRESENT;
    end
    always_comb begin
        load_evt = (state == IDLE) && |slot_pending;
        accept   = (state == PRESENT) && event_ready;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            event_valid  <= 1'b0;
            event_id     <= 2'd0;
            event_target <= '0;
            rr           <= 2'd0;
        end else begin
            event_valid <= (next_state == PRESENT);
            if (load_evt) begin
                event_id     <= pick;
                event_target <= fire_val[pick];
            end
            if (accept) rr <= event_id + 2'd1;
        end
    end
    // A same-cycle due re-arms pending even while that slot's event is being accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_enable  <= '0;
            slot_pending <= '0;
            for (int i = 0; i < NUM_SLOT; i++) begin
                target[i]   <= '0;
                period[i]   <= '0;
                fire_val[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOT; i++) begin
                if (wr_hit[i]) begin
                    target[i]      <= cfg_target;
                    period[i]      <= cfg_period;
                    slot_enable[i] <= cfg_enable;
                end else if (due[i]) begin
                    fire_val[i] <= target[i];
                    if (period[i] != '0) target[i] <= target[i] + TIMER_WIDTH'(period[i]);
                    else                 slot_enable[i] <= 1'b0;
                end
                slot_pending[i] <= due[i] || (slot_pending[i] && !accept_hit[i]);
            end
        end
    end
`ifdef TSF_EVENT_MISS_CNT_EN
    // Overrun: fired again before the previous firing was consumed
    logic [NUM_SLOT-1:0] overrun;
    always_comb begin
        for (int i = 0; i < NUM_SLOT; i++)
            overrun[i] = due[i] && slot_pending[i] && !accept_hit[i];
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) miss_cnt <= '0;
        else begin
            for (int i = 0; i < NUM_SLOT; i++) begin
                if (wr_hit[i])                                        miss_cnt[8*i +: 8] <= 8'd0;
                else if (overrun[i] && miss_cnt[8*i +: 8] != 8'hff) miss_cnt[8*i +: 8] <= miss_cnt[8*i +: 8] + 8'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_tsf_event_scheduler.sv
// tb_tsf_event_scheduler: directed checks of firing, periodic reload, round-robin order,
// backpressure, TSF jumps and asynchronous reset of tsf_event_scheduler.
module tb_tsf_event_scheduler;
    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] tsf_runtime_val;
    logic        cfg_wr;
    logic [1:0]  cfg_slot;
    logic        cfg_enable;
    logic [63:0] cfg_target;
    logic [31:0] cfg_period;
    logic        event_valid;
    logic        event_ready;
    logic [1:0]  event_id;
    logic [63:0] event_target;
    logic [3:0]  slot_enable;
    logic [3:0]  slot_pending;
`ifdef TSF_EVENT_MISS_CNT_EN
    logic [31:0] miss_cnt;
`endif
    int vecs = 0;
    int errs = 0;
    bit run  = 1'b0;

    tsf_event_scheduler dut (
        .clk(clk), .rstn(rstn), .tsf_runtime_val(tsf_runtime_val),
        .cfg_wr(cfg_wr), .cfg_slot(cfg_slot), .cfg_enable(cfg_enable),
        .cfg_target(cfg_target), .cfg_period(cfg_period),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_id(event_id), .event_target(event_target),
`ifdef TSF_EVENT_MISS_CNT_EN
        .miss_cnt(miss_cnt),
`endif
        .slot_enable(slot_enable), .slot_pending(slot_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    // Outputs are observed right after the falling edge, then TSF advances when running
    task automatic cyc();
        @(negedge clk);
        if (run) tsf_runtime_val = tsf_runtime_val + 64'd1;
    endtask

    task automatic cfg(input logic [1:0] s, input logic en, input logic [63:0] t, input logic [31:0] p);
        cfg_wr = 1'b1; cfg_slot = s; cfg_enable = en; cfg_target = t; cfg_period = p;
        cyc();
        cfg_wr = 1'b0;
    endtask

    task automatic wait_ev(input int max, output bit found);
        int n = 0;
        while (!event_valid && n < max) begin
            cyc();
            n++;
        end
        found = event_valid;
    endtask

    task automatic test_reset();
        #3;
        vecs++; if (event_valid !== 1'b0 || event_id !== 2'd0 || event_target !== 64'd0) begin
            errs++; $display("FAIL reset_event: got valid=%b id=%0d target=%0d want 0/0/0", event_valid, event_id, event_target);
        end
        vecs++; if (slot_enable !== 4'd0 || slot_pending !== 4'd0) begin
            errs++; $display("FAIL reset_status: got en=%b pend=%b want 0000/0000", slot_enable, slot_pending);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_simultaneous();
        logic [1:0] ids [3] = '{2'd0, 2'd2, 2'd3};
        bit found;
        for (int r = 0; r < 2; r++) begin
            logic [63:0] base = 64'(200 * (r + 1));
            tsf_runtime_val = base - 64'd100;
            cfg(2'd0, 1'b1, base, 32'd0);
            cfg(2'd2, 1'b1, base, 32'd0);
            cfg(2'd3, 1'b1, base, 32'd0);
            tsf_runtime_val = base;
            wait_ev(5, found);
            for (int j = 0; j < 3; j++) begin
                if (j > 0) begin
                    cyc();
                    vecs++; if (event_valid !== 1'b0) begin
                        errs++; $display("FAIL simul_gap r%0d j%0d: got valid=%b want 0", r, j, event_valid);
                    end
                    cyc();
                end
                vecs++; if (!event_valid || event_id !== ids[j] || event_target !== base) begin
                    errs++; $display("FAIL simul_order r%0d j%0d: got valid=%b id=%0d target=%0d want 1/%0d/%0d", r, j, event_valid, event_id, event_target, ids[j], base);
                end
            end
            cyc();
            vecs++; if (event_valid !== 1'b0 || slot_pending !== 4'd0) begin
                errs++; $display("FAIL simul_drain r%0d: got valid=%b pend=%b want 0/0000", r, event_valid, slot_pending);
            end
        end
    endtask

    task automatic test_one_shot();
        bit found;
        tsf_runtime_val = 64'd0;
        cfg(2'd1, 1'b1, 64'd1000, 32'd0);
        run = 1'b1;
        wait_ev(1100, found);
        vecs++; if (!found || tsf_runtime_val !== 64'd1002) begin
            errs++; $display("FAIL one_shot_latency: got found=%b tsf=%0d want 1/1002", found, tsf_runtime_val);
        end
        vecs++; if (event_id !== 2'd1 || event_target !== 64'd1000) begin
            errs++; $display("FAIL one_shot_event: got id=%0d target=%0d want 1/1000", event_id, event_target);
        end
        cyc();
        vecs++; if (event_valid !== 1'b0 || slot_enable[1] !== 1'b0 || slot_pending !== 4'd0) begin
            errs++; $display("FAIL one_shot_after: got valid=%b en1=%b pend=%b want 0/0/0000", event_valid, slot_enable[1], slot_pending);
        end
        wait_ev(50, found);
        vecs++; if (found) begin
            errs++; $display("FAIL one_shot_refire: got an event id=%0d want none", event_id);
        end
        run = 1'b0;
    endtask

    task automatic test_periodic();
        bit found;
        tsf_runtime_val = 64'd400;
        cfg(2'd0, 1'b1, 64'd500, 32'd100);
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ev(150, found);
            vecs++; if (!found || event_id !== 2'd0 || event_target !== 64'(500 + 100 * k) || tsf_runtime_val !== 64'(502 + 100 * k)) begin
                errs++; $display("FAIL periodic_%0d: got found=%b id=%0d target=%0d tsf=%0d want 1/0/%0d/%0d", k, found, event_id, event_target, tsf_runtime_val, 500 + 100 * k, 502 + 100 * k);
            end
            cyc();
        end
        vecs++; if (slot_enable[0] !== 1'b1) begin
            errs++; $display("FAIL periodic_enable: got en0=%b want 1", slot_enable[0]);
        end
        run = 1'b0;
        cfg(2'd0, 1'b0, 64'd0, 32'd0);
    endtask

    task automatic test_backpressure();
        bit found;
        bit moved = 1'b0;
        tsf_runtime_val = 64'd2000;
        cfg(2'd0, 1'b1, 64'd2010, 32'd10);
        event_ready = 1'b0;
        run = 1'b1;
        wait_ev(30, found);
        vecs++; if (!found || event_target !== 64'd2010 || tsf_runtime_val !== 64'd2012) begin
            errs++; $display("FAIL bp_first: got found=%b target=%0d tsf=%0d want 1/2010/2012", found, event_target, tsf_runtime_val);
        end
        repeat (50) begin
            cyc();
            if (!event_valid || event_id !== 2'd0 || event_target !== 64'd2010) moved = 1'b1;
        end
        vecs++; if (moved) begin
            errs++; $display("FAIL bp_frozen: got valid=%b id=%0d target=%0d want stable 1/0/2010", event_valid, event_id, event_target);
        end
`ifdef TSF_EVENT_MISS_CNT_EN
        vecs++; if (miss_cnt[7:0] !== 8'd4 && miss_cnt[7:0] !== 8'd5) begin
            errs++; $display("FAIL bp_miss_cnt: got %0d want 4 or 5", miss_cnt[7:0]);
        end
`endif
        event_ready = 1'b1;
        cyc();
        vecs++; if (event_valid !== 1'b0 || slot_pending[0] !== 1'b0) begin
            errs++; $display("FAIL bp_single: got valid=%b pend0=%b want 0/0", event_valid, slot_pending[0]);
        end
        wait_ev(20, found);
        vecs++; if (!found || event_target !== 64'd2070 || tsf_runtime_val !== 64'd2072) begin
            errs++; $display("FAIL bp_next: got found=%b target=%0d tsf=%0d want 1/2070/2072", found, event_target, tsf_runtime_val);
        end
        run = 1'b0;
        cfg(2'd0, 1'b0, 64'd0, 32'd0);
    endtask

    task automatic test_jump();
        bit bad = 1'b0;
        tsf_runtime_val = 64'd100;
        cfg(2'd3, 1'b1, 64'd5000, 32'd0);
        cyc();
        vecs++; if (event_valid !== 1'b0 || slot_pending !== 4'd0) begin
            errs++; $display("FAIL jump_pre: got valid=%b pend=%b want 0/0000", event_valid, slot_pending);
        end
        tsf_runtime_val = 64'd10000;
        cyc();
        vecs++; if (event_valid !== 1'b0 || slot_pending !== 4'b1000) begin
            errs++; $display("FAIL jump_pending: got valid=%b pend=%b want 0/1000", event_valid, slot_pending);
        end
        cyc();
        vecs++; if (!event_valid || event_id !== 2'd3 || event_target !== 64'd5000) begin
            errs++; $display("FAIL jump_fwd: got valid=%b id=%0d target=%0d want 1/3/5000", event_valid, event_id, event_target);
        end
        cyc();
        tsf_runtime_val = 64'd5990;
        cfg(2'd3, 1'b1, 64'd6000, 32'd0);
        tsf_runtime_val = 64'd1000;
        repeat (5) begin
            cyc();
            if (event_valid || slot_pending != 4'd0) bad = 1'b1;
        end
        vecs++; if (bad) begin
            errs++; $display("FAIL jump_back: got an event or pending after backward jump, want none");
        end
        tsf_runtime_val = 64'd6000;
        cyc();
        cyc();
        vecs++; if (!event_valid || event_id !== 2'd3 || event_target !== 64'd6000) begin
            errs++; $display("FAIL jump_catchup: got valid=%b id=%0d target=%0d want 1/3/6000", event_valid, event_id, event_target);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        tsf_runtime_val = 64'd6900;
        event_ready = 1'b0;
        cfg(2'd2, 1'b1, 64'd7000, 32'd50);
        tsf_runtime_val = 64'd7000;
        cyc();
        cyc();
        vecs++; if (!event_valid || event_id !== 2'd2) begin
            errs++; $display("FAIL rst_mid_setup: got valid=%b id=%0d want 1/2", event_valid, event_id);
        end
        #2 rstn = 1'b0;
        #1;
        vecs++; if (event_valid !== 1'b0 || event_target !== 64'd0 || slot_enable !== 4'd0 || slot_pending !== 4'd0) begin
            errs++; $display("FAIL rst_mid_async: got valid=%b target=%0d en=%b pend=%b want 0/0/0000/0000", event_valid, event_target, slot_enable, slot_pending);
        end
        @(negedge clk);
        rstn = 1'b1;
        event_ready = 1'b1;
        repeat (5) begin
            cyc();
            if (event_valid || slot_pending != 4'd0 || slot_enable != 4'd0) bad = 1'b1;
        end
        vecs++; if (bad) begin
            errs++; $display("FAIL rst_mid_replay: got valid=%b en=%b pend=%b want no event, status 0", event_valid, slot_enable, slot_pending);
        end
    endtask

    initial begin
        rstn = 1'b0;
        tsf_runtime_val = 64'd100;
        cfg_wr = 1'b0; cfg_slot = 2'd0; cfg_enable = 1'b0; cfg_target = 64'd0; cfg_period = 32'd0;
        event_ready = 1'b1;
        test_reset();
        test_simultaneous();
        test_one_shot();
        test_periodic();
        test_backpressure();
        test_jump();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
